// File: rtl/priv_pkg.sv
// Shared types and constants for the privilege/trap sequencer: privilege
// encodings, FSM states, CSR addresses, mstatus bit positions and cause codes.
package priv_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEDELEG = 12'h302;

  localparam int SIE_BIT  = 1;
  localparam int MIE_BIT  = 3;
  localparam int SPIE_BIT = 5;
  localparam int MPIE_BIT = 7;
  localparam int SPP_BIT  = 8;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  localparam int CAUSE_ILLEGAL_INSN = 2;
  localparam int CAUSE_BREAKPOINT   = 3;
  localparam int CAUSE_ECALL_U      = 8;
  localparam int CAUSE_ECALL_S      = 9;
  localparam int CAUSE_ECALL_M      = 11;

  // MPP is WARL: only privilege levels this hart implements are accepted.
  function automatic logic mpp_legal(input logic [1:0] v, input logic has_s);
    return (v == PRIV_M) || (v == PRIV_U) || (has_s && (v == PRIV_S));
  endfunction

endpackage

// File: rtl/exc_prio_arb.sv
// Fixed-priority arbiter: the lowest-index request (oldest pipeline stage)
// wins; grant is one-hot.
module exc_prio_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [N-1:0] grant
);

  assign valid = |req;
  // Isolate the lowest set bit.
  assign grant = req & (~req + N'(1));

endmodule

// File: rtl/priv_trap_unit.sv
// Privilege and trap sequencer: arbitrates stage exceptions, owns the
// privilege status bits, sequences trap entry / xRET and issues the redirect.
module priv_trap_unit
  import priv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 4,
  parameter int HAS_S_MODE = 1,
  parameter int CAUSE_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  input  logic [NUM_SRC*XLEN-1:0]    exc_pc,
  input  logic [NUM_SRC*XLEN-1:0]    exc_tval,
  input  logic                       mret_commit,
  input  logic                       sret_commit,
  input  logic [XLEN-1:0]            mtvec,
  input  logic [XLEN-1:0]            stvec,
  input  logic [XLEN-1:0]            mepc,
  input  logic [XLEN-1:0]            sepc,
  input  logic                       csr_we,
  input  logic [11:0]                csr_addr,
  input  logic [XLEN-1:0]            csr_wdata,
  output logic [1:0]                 cur_priv,
  output logic [XLEN-1:0]            mstatus_o,
  output logic [XLEN-1:0]            medeleg_o,
  output logic                       trap_we,
  output logic                       trap_to_s,
  output logic [CAUSE_W-1:0]         trap_cause,
  output logic [XLEN-1:0]            trap_epc,
  output logic [XLEN-1:0]            trap_tval,
  output logic                       stall,
  output logic                       redirect_valid,
  output logic [XLEN-1:0]            redirect_pc,
  input  logic                       redirect_ready
);

  // Handshake: redirect_valid rises with redirect_pc and both hold unchanged
  // until redirect_ready is sampled high on a rising clk edge; that edge
  // completes the transfer and the sequencer returns to IDLE.

  localparam logic            HAS_S        = (HAS_S_MODE != 0);
  localparam logic [XLEN-1:0] VEC_MASK     = ~XLEN'(3);
  localparam logic [XLEN-1:0] MEDELEG_MASK = ~(XLEN'(1) << CAUSE_ECALL_M);

  state_t state, state_next;

  logic [1:0]         priv_q;
  logic               mie_q, sie_q, mpie_q, spie_q, spp_q;
  logic [1:0]         mpp_q;
  logic [XLEN-1:0]    medeleg_q;
  logic [CAUSE_W-1:0] lat_cause;
  logic [XLEN-1:0]    lat_epc, lat_tval, target_q;

  logic               arb_valid;
  logic [NUM_SRC-1:0] arb_grant;
  logic [CAUSE_W-1:0] sel_cause;
  logic [XLEN-1:0]    sel_pc, sel_tval;
  logic               idle, exc_take, mret_take, sret_take, deleg;

  exc_prio_arb #(.N(NUM_SRC)) u_arb (
    .req   (exc_valid),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  always_comb begin
    sel_cause = '0;
    sel_pc    = '0;
    sel_tval  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant[i]) begin
        sel_cause = exc_cause[i*CAUSE_W +: CAUSE_W];
        sel_pc    = exc_pc[i*XLEN +: XLEN];
        sel_tval  = exc_tval[i*XLEN +: XLEN];
      end
    end
  end

  // A losing xRET is simply dropped: the exception flushes it.
  assign idle      = (state == ST_IDLE);
  assign exc_take  = idle && arb_valid;
  assign mret_take = idle && !arb_valid && mret_commit;
  assign sret_take = idle && !arb_valid && !mret_commit && sret_commit &&
                     HAS_S && (priv_q != PRIV_U);
  assign deleg     = HAS_S && (priv_q != PRIV_M) && medeleg_q[lat_cause];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (exc_take)                    state_next = ST_TRAP;
        else if (mret_take || sret_take) state_next = ST_REDIR;
      end
      ST_TRAP:  state_next = ST_REDIR;
      ST_REDIR: if (redirect_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    trap_we        = 1'b0;
    trap_to_s      = 1'b0;
    trap_cause     = '0;
    trap_epc       = '0;
    trap_tval      = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      ST_IDLE: stall = exc_take || mret_take || sret_take;
      ST_TRAP: begin
        trap_we    = 1'b1;
        trap_to_s  = deleg;
        trap_cause = lat_cause;
        trap_epc   = lat_epc;
        trap_tval  = lat_tval;
        stall      = 1'b1;
      end
      ST_REDIR: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  // CSR writes first; trap/xRET updates later in the block win per field.
  always_ff @(posedge clk) begin
    if (rst) begin
      priv_q    <= PRIV_M;
      mie_q     <= 1'b0;
      sie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      spie_q    <= 1'b0;
      spp_q     <= 1'b0;
      mpp_q     <= PRIV_M;
      medeleg_q <= '0;
      lat_cause <= '0;
      lat_epc   <= '0;
      lat_tval  <= '0;
      target_q  <= '0;
    end else begin
      if (csr_we) begin
        if (csr_addr == CSR_MSTATUS) begin
          mie_q  <= csr_wdata[MIE_BIT];
          mpie_q <= csr_wdata[MPIE_BIT];
          if (mpp_legal(csr_wdata[MPP_HI:MPP_LO], HAS_S)) mpp_q <= csr_wdata[MPP_HI:MPP_LO];
        end
        if (HAS_S && (csr_addr == CSR_MSTATUS || csr_addr == CSR_SSTATUS)) begin
          sie_q  <= csr_wdata[SIE_BIT];
          spie_q <= csr_wdata[SPIE_BIT];
          spp_q  <= csr_wdata[SPP_BIT];
        end
        if (csr_addr == CSR_MEDELEG) medeleg_q <= csr_wdata & MEDELEG_MASK;
      end

      if (exc_take) begin
        lat_cause <= sel_cause;
        lat_epc   <= sel_pc;
        lat_tval  <= sel_tval;
      end else if (mret_take) begin
        priv_q   <= mpp_q;
        mie_q    <= mpie_q;
        mpie_q   <= 1'b1;
        mpp_q    <= PRIV_U;
        target_q <= mepc;
      end else if (sret_take) begin
        priv_q   <= {1'b0, spp_q};
        sie_q    <= spie_q;
        spie_q   <= 1'b1;
        spp_q    <= 1'b0;
        target_q <= sepc;
      end

      if (state == ST_TRAP) begin
        if (deleg) begin
          spp_q    <= priv_q[0];
          spie_q   <= sie_q;
          sie_q    <= 1'b0;
          priv_q   <= PRIV_S;
          target_q <= stvec & VEC_MASK;
        end else begin
          mpp_q    <= priv_q;
          mpie_q   <= mie_q;
          mie_q    <= 1'b0;
          priv_q   <= PRIV_M;
          target_q <= mtvec & VEC_MASK;
        end
      end
    end
  end

  always_comb begin
    mstatus_o                = '0;
    mstatus_o[SIE_BIT]       = sie_q;
    mstatus_o[MIE_BIT]       = mie_q;
    mstatus_o[SPIE_BIT]      = spie_q;
    mstatus_o[MPIE_BIT]      = mpie_q;
    mstatus_o[SPP_BIT]       = spp_q;
    mstatus_o[MPP_HI:MPP_LO] = mpp_q;
  end

  assign cur_priv  = priv_q;
  assign medeleg_o = medeleg_q;

endmodule
